// File: rtl/ysyx_22050518_cache_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050518_cache_pkg
// Shared definitions for the n-way cache tag array:
//   - default geometry constants (sets, ways, tag width)
//   - sweep FSM state encoding
//   - per-way status struct {valid, dirty}; the tag half of an entry is
//     kept in a separate array so a sweep can clear status without
//     touching tag storage
// ----------------------------------------------------------------------------
package ysyx_22050518_cache_pkg;

  localparam int SETS_DEF  = 128;
  localparam int WAYS_DEF  = 4;
  localparam int TAG_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } sweep_state_e;

  typedef struct packed {
    logic valid;
    logic dirty;
  } entry_meta_t;

endpackage

// File: rtl/ysyx_22050518_plru_tree.sv
// ----------------------------------------------------------------------------
// ysyx_22050518_plru_tree
// Combinational tree-PLRU for one set (WAYS-1 state bits, heap order: node k
// lives in bit k-1, children of k are 2k and 2k+1).  The root decides way
// bit 0, the next level way bit 1, and so on.  A state bit names the side
// that should be evicted next (0 = the half whose current way bit is 0).
// Ports:
//   lk_state / lk_way  -> lk_victim, lk_next : victim of the looked-up set and
//                                              its state after touching lk_way
//   wr_state / wr_way  -> wr_next            : state of the written set after
//                                              touching wr_way
// ----------------------------------------------------------------------------
module ysyx_22050518_plru_tree #(
  parameter int  WAYS  = 4,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int PL_W  = (WAYS > 1) ? (WAYS - 1) : 1
) (
  input  logic [PL_W-1:0]  lk_state,
  input  logic [WAY_W-1:0] lk_way,
  output logic [WAY_W-1:0] lk_victim,
  output logic [PL_W-1:0]  lk_next,
  input  logic [PL_W-1:0]  wr_state,
  input  logic [WAY_W-1:0] wr_way,
  output logic [PL_W-1:0]  wr_next
);

  localparam int LVL = (WAYS > 1) ? $clog2(WAYS) : 0;

  // Walk root-to-leaf along way's bits, pointing every node on the path away.
  function automatic logic [PL_W-1:0] touch(input logic [PL_W-1:0] st,
                                            input logic [WAY_W-1:0] way);
    logic [PL_W-1:0] nxt;
    int              node;
    nxt  = st;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      nxt[node-1] = ~way[l];
      node        = 2 * node + int'(way[l]);
    end
    return nxt;
  endfunction

  int vic_node_s;

  // Victim: follow the stored pointers from the root down.
  always_comb begin
    lk_victim  = '0;
    vic_node_s = 1;
    for (int l = 0; l < LVL; l++) begin
      lk_victim[l] = lk_state[vic_node_s-1];
      vic_node_s   = 2 * vic_node_s + int'(lk_state[vic_node_s-1]);
    end
  end

  assign lk_next = touch(lk_state, lk_way);
  assign wr_next = touch(wr_state, wr_way);

endmodule

// File: rtl/ysyx_22050518_tag_array_nway.sv
// ----------------------------------------------------------------------------
// ysyx_22050518_tag_array_nway
// Set-associative tag array with per-set tree-PLRU and an init/flush sweep.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   flush_req            : start a sweep that invalidates every set (IDLE only)
//   flush_busy           : sweep in progress; lookups and writes are refused
//   lk_valid/lk_ready    : lookup handshake, lk_index/lk_tag select set and tag
//   rsp_*                : registered lookup result, valid one cycle after
//                          acceptance, fields held until the next result
//   wr_en/wr_index/wr_way/wr_tag/wr_vld/wr_dirty : single-entry write
// Storage arrays carry no reset so they can map onto RAM; the sweep clears
// status and PLRU bits one set per cycle instead.
// ----------------------------------------------------------------------------
module ysyx_22050518_tag_array_nway
  import ysyx_22050518_cache_pkg::*;
#(
  parameter int  SETS  = SETS_DEF,
  parameter int  WAYS  = WAYS_DEF,
  parameter int  TAG_W = TAG_W_DEF,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_req,
  output logic             flush_busy,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_dirty,
  output logic             rsp_vic_valid,
  output logic [TAG_W-1:0] rsp_vic_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_vld,
  input  logic             wr_dirty
);

  localparam int PL_W = (WAYS > 1) ? (WAYS - 1) : 1;

  entry_meta_t [WAYS-1:0]            meta_mem_r [SETS];
  logic        [WAYS-1:0][TAG_W-1:0] tag_mem_r  [SETS];
  logic        [PL_W-1:0]            plru_mem_r [SETS];

  sweep_state_e     state_r;
  sweep_state_e     state_nxt_s;
  logic [IDX_W-1:0] sweep_idx_r;
  logic             sweep_last_s;
  logic             busy_s;
  logic             lk_fire_s;
  logic             wr_fire_s;

  entry_meta_t [WAYS-1:0]            lk_meta_s;
  logic        [WAYS-1:0][TAG_W-1:0] lk_tags_s;
  logic        [PL_W-1:0]            lk_plru_s;
  logic        [PL_W-1:0]            wr_plru_s;
  logic        [PL_W-1:0]            lk_plru_nxt_s;
  logic        [PL_W-1:0]            wr_plru_nxt_s;
  logic        [WAY_W-1:0]           plru_vic_s;

  logic             hit_s;
  logic [WAY_W-1:0] hit_way_s;
  logic             inv_s;
  logic [WAY_W-1:0] inv_way_s;
  logic [WAY_W-1:0] sel_way_s;
  logic             same_set_wr_s;

  assign busy_s       = (state_r != ST_IDLE);
  assign flush_busy   = busy_s;
  assign lk_ready     = ~busy_s;
  assign lk_fire_s    = lk_valid & ~busy_s;
  assign wr_fire_s    = wr_en & ~busy_s;
  assign sweep_last_s = (sweep_idx_r == IDX_W'(SETS - 1));

  assign lk_meta_s = meta_mem_r[lk_index];
  assign lk_tags_s = tag_mem_r[lk_index];
  assign lk_plru_s = plru_mem_r[lk_index];
  assign wr_plru_s = plru_mem_r[wr_index];

  // A write to the set being looked up owns that set's PLRU update.
  assign same_set_wr_s = wr_fire_s & (wr_index == lk_index);

  ysyx_22050518_plru_tree #(.WAYS(WAYS)) u_plru (
    .lk_state  (lk_plru_s),
    .lk_way    (hit_way_s),
    .lk_victim (plru_vic_s),
    .lk_next   (lk_plru_nxt_s),
    .wr_state  (wr_plru_s),
    .wr_way    (wr_way),
    .wr_next   (wr_plru_nxt_s)
  );

  // Sweep FSM next state: sweeps run to completion, flush only starts from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT, ST_FLUSH: begin
        if (sweep_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_IDLE: begin
        if (flush_req) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM state and sweep counter; counter wraps to 0 on the last set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      sweep_idx_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (busy_s) begin
        sweep_idx_r <= sweep_idx_r + IDX_W'(1);
      end else begin
        sweep_idx_r <= '0;
      end
    end
  end

  // Tag compare (lowest matching way wins) and lowest invalid way search.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    inv_s     = 1'b0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = (lk_meta_s[w].valid && (lk_tags_s[w] == lk_tag)) ? WAY_W'(w) : hit_way_s;
      hit_s     = hit_s | (lk_meta_s[w].valid && (lk_tags_s[w] == lk_tag));
      inv_way_s = (!lk_meta_s[w].valid) ? WAY_W'(w) : inv_way_s;
      inv_s     = inv_s | !lk_meta_s[w].valid;
    end
    if (hit_s) begin
      sel_way_s = hit_way_s;
    end else if (inv_s) begin
      sel_way_s = inv_way_s;
    end else begin
      sel_way_s = plru_vic_s;
    end
  end

  // Registered lookup response; fields hold between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_way       <= '0;
      rsp_dirty     <= 1'b0;
      rsp_vic_valid <= 1'b0;
      rsp_vic_tag   <= '0;
    end else begin
      rsp_valid <= lk_fire_s;
      if (lk_fire_s) begin
        rsp_hit       <= hit_s;
        rsp_way       <= sel_way_s;
        rsp_dirty     <= lk_meta_s[sel_way_s].dirty;
        rsp_vic_valid <= lk_meta_s[sel_way_s].valid;
        rsp_vic_tag   <= lk_tags_s[sel_way_s];
      end
    end
  end

  // Storage: sweep clear, entry write with MRU update, hit PLRU update.
  always_ff @(posedge clk) begin
    if (busy_s) begin
      meta_mem_r[sweep_idx_r] <= '0;
      plru_mem_r[sweep_idx_r] <= '0;
    end else begin
      if (wr_fire_s) begin
        meta_mem_r[wr_index][wr_way] <= {wr_vld, wr_dirty};
        tag_mem_r[wr_index][wr_way]  <= wr_tag;
        plru_mem_r[wr_index]         <= wr_plru_nxt_s;
      end
      if (lk_fire_s && hit_s && !same_set_wr_s) begin
        plru_mem_r[lk_index] <= lk_plru_nxt_s;
      end
    end
  end

endmodule
